// File: rtl/sysctrl_pkg.sv
// Shared definitions for the sysctrl byte-frame initiator: FSM states,
// target command codes and the constant boot frame table.
package sysctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BOOT,
    SEND_CMD,
    SEND_DATA,
    WAIT,
    DONE
  } state_t;

  localparam logic [7:0] CMD_STATUS  = 8'h00;
  localparam logic [7:0] CMD_LEDS    = 8'h01;
  localparam logic [7:0] CMD_COLOR   = 8'h02;
  localparam logic [7:0] CMD_BUTTONS = 8'h03;
  localparam logic [7:0] CMD_CONFIG  = 8'h04;
  localparam logic [7:0] CMD_INT     = 8'h05;
  localparam logic [7:0] CMD_INTSRC  = 8'h06;
  localparam logic [7:0] CMD_PORT_RD = 8'h07;
  localparam logic [7:0] CMD_PORT_WR = 8'h08;

  // One boot frame: command, payload length and up to two payload bytes
  // (byte k at data[8k+7:8k]).
  typedef struct packed {
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [15:0] data;
  } boot_frame_t;

  localparam int unsigned BOOT_FRAMES = 3;

  localparam boot_frame_t BOOT_TABLE [BOOT_FRAMES] = '{
    '{cmd: CMD_INT,    len: 4'd1, data: 16'h0001},  // interrupt ack
    '{cmd: CMD_CONFIG, len: 4'd2, data: 16'h0241},  // "A" <= 0x02
    '{cmd: CMD_CONFIG, len: 4'd2, data: 16'h0052}   // "R" <= 0x00
  };

endpackage

// File: rtl/sysctrl_strobe_pacer.sv
// Inter-strobe gap counter. Loaded on every strobe; flags the last idle
// cycle before the next strobe, and a capture pulse in that same cycle when
// the strobe that loaded it carried a payload byte.
module sysctrl_strobe_pacer #(
  parameter int unsigned GAP = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic load_payload,
  output logic next_strobe,
  output logic capture
);

  localparam int unsigned CW = $clog2(GAP + 1);

  logic [CW-1:0] cnt;
  logic          payload_q;

  // Gap countdown, restarted by each strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      payload_q <= 1'b0;
    end else if (load) begin
      cnt       <= CW'(GAP);
      payload_q <= load_payload;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign next_strobe = (cnt == CW'(1));
  assign capture     = next_strobe && payload_q;

endmodule

// File: rtl/sysctrl_initiator.sv
// FPGA-side initiator for the MCU byte-frame protocol: sends a command byte
// with start, then the payload bytes, capturing the target response after
// each payload strobe.
// Optional: define SYSCTRL_INIT_BOOTROM_EN to play the package boot frame
// table after reset before accepting requests.
module sysctrl_initiator
  import sysctrl_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned GAP     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [7:0]           req_cmd,
  input  logic [3:0]           req_len,
  input  logic [8*MAX_LEN-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [8*MAX_LEN-1:0] rsp_rdata,
  output logic                 busy,
  output logic                 data_in_strobe,
  output logic                 data_in_start,
  output logic [7:0]           data_in,
  input  logic [7:0]           data_out
);

  state_t               state, state_nx;
  logic [7:0]           cmd_q;
  logic [3:0]           len_q;
  logic [3:0]           idx;
  logic [8*MAX_LEN-1:0] wbuf;
  logic [8*MAX_LEN-1:0] rbuf;
  logic [7:0]           din_q;
  logic [7:0]           wbyte;
  logic                 accept;
  logic                 next_strobe;
  logic                 capture;
  logic                 boot_mode;

`ifdef SYSCTRL_INIT_BOOTROM_EN
  localparam state_t RESET_STATE = BOOT;
  logic [1:0] boot_idx;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  function automatic logic [3:0] clamp_len(input logic [3:0] l);
    return (l > 4'(MAX_LEN)) ? 4'(MAX_LEN) : l;
  endfunction

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE) && !boot_mode;
  assign rsp_rdata = rbuf;

  sysctrl_strobe_pacer #(.GAP(GAP)) u_pacer (
    .clk          (clk),
    .reset        (reset),
    .load         (data_in_strobe),
    .load_payload (state == SEND_DATA),
    .next_strobe  (next_strobe),
    .capture      (capture)
  );

  // Next-state and strobe outputs; data_in falls back to the held byte.
  always_comb begin
    state_nx       = state;
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
    data_in        = din_q;
    wbyte          = '0;
    for (int unsigned k = 0; k < MAX_LEN; k++) begin
      if (idx == 4'(k)) wbyte = wbuf[8*k +: 8];
    end
    case (state)
      IDLE:      if (accept) state_nx = SEND_CMD;
      BOOT:      state_nx = SEND_CMD;
      SEND_CMD: begin
        data_in_strobe = 1'b1;
        data_in_start  = 1'b1;
        data_in        = cmd_q;
        state_nx       = WAIT;
      end
      SEND_DATA: begin
        data_in_strobe = 1'b1;
        data_in        = wbyte;
        state_nx       = WAIT;
      end
      WAIT:      if (next_strobe) state_nx = (idx == len_q) ? DONE : SEND_DATA;
      DONE: begin
        state_nx = IDLE;
`ifdef SYSCTRL_INIT_BOOTROM_EN
        if (boot_mode && (boot_idx != 2'(BOOT_FRAMES))) state_nx = BOOT;
`endif
      end
      default:   state_nx = IDLE;
    endcase
  end

  // State register, request latching, payload index and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_STATE;
      cmd_q <= '0;
      len_q <= '0;
      idx   <= '0;
      wbuf  <= '0;
      rbuf  <= '0;
      din_q <= '0;
    end else begin
      state <= state_nx;
      din_q <= data_in;
      if (accept) begin
        cmd_q <= req_cmd;
        len_q <= clamp_len(req_len);
        wbuf  <= req_wdata;
      end
      if (state == SEND_CMD)  idx <= '0;
      if (state == SEND_DATA) idx <= idx + 4'd1;
      // idx has already advanced past the byte whose response is captured.
      if (capture) begin
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
          if (idx == 4'(k + 1)) rbuf[8*k +: 8] <= data_out;
        end
      end
`ifdef SYSCTRL_INIT_BOOTROM_EN
      if (state == BOOT) begin
        cmd_q <= BOOT_TABLE[boot_idx].cmd;
        len_q <= clamp_len(BOOT_TABLE[boot_idx].len);
        wbuf  <= (8*MAX_LEN)'(BOOT_TABLE[boot_idx].data);
      end
`endif
    end
  end

`ifdef SYSCTRL_INIT_BOOTROM_EN
  // Boot table sequencing; responses stay suppressed until IDLE is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      boot_idx  <= '0;
      boot_mode <= 1'b1;
    end else begin
      if (state == BOOT)     boot_idx  <= boot_idx + 2'd1;
      if (state_nx == IDLE)  boot_mode <= 1'b0;
    end
  end
`else
  assign boot_mode = 1'b0;
`endif

endmodule

// File: tb/tb_sysctrl_initiator.sv
// Self-checking bench for sysctrl_initiator with a small sysctrl-like target
// model (MAX_LEN=8, GAP=4).
module tb_sysctrl_initiator;
  import sysctrl_pkg::*;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned GAP     = 4;

`ifdef SYSCTRL_INIT_BOOTROM_EN
  localparam logic BOOT_EN = 1'b1;
`else
  localparam logic BOOT_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [7:0]           req_cmd = '0;
  logic [3:0]           req_len = '0;
  logic [8*MAX_LEN-1:0] req_wdata = '0;
  logic                 rsp_valid;
  logic [8*MAX_LEN-1:0] rsp_rdata;
  logic                 busy;
  logic                 data_in_strobe;
  logic                 data_in_start;
  logic [7:0]           data_in;
  logic [7:0]           data_out;

  int checks   = 0;
  int failures = 0;

  sysctrl_initiator #(.MAX_LEN(MAX_LEN), .GAP(GAP)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cmd        (req_cmd),
    .req_len        (req_len),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .busy           (busy),
    .data_in_strobe (data_in_strobe),
    .data_in_start  (data_in_start),
    .data_in        (data_in),
    .data_out       (data_out)
  );

  always #5 clk = ~clk;

  // Target model: STATUS returns a fixed byte table, CONFIG reg "A" sets the
  // volume, every other payload byte is answered with its complement.
  logic [7:0] m_cmd, m_reg, m_vol;
  logic [3:0] m_k;
  always @(posedge clk) begin
    if (reset) begin
      data_out <= '0; m_cmd <= '0; m_reg <= '0; m_vol <= '0; m_k <= '0;
    end else if (data_in_strobe) begin
      if (data_in_start) begin
        m_cmd <= data_in; m_k <= '0; data_out <= '0;
      end else begin
        m_k <= m_k + 4'd1;
        if (m_cmd == CMD_STATUS) begin
          case (m_k)
            4'd0:    data_out <= 8'h5C;
            4'd1:    data_out <= 8'h42;
            4'd2:    data_out <= 8'h02;
            default: data_out <= 8'h00;
          endcase
        end else begin
          data_out <= ~data_in;
          if (m_cmd == CMD_CONFIG) begin
            if (m_k == 4'd0) m_reg <= data_in;
            else if (m_k == 4'd1 && m_reg == 8'h41) m_vol <= data_in;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [63:0] wd;
    int          lat;
    logic [63:0] rd;
  } vec_t;

  // One request from IDLE: checks strobe timing/content, latency and rsp_rdata.
  task automatic run_frame(input string tag, input vec_t v);
    int         lat;
    int         n_exp;
    int         srel[$];
    logic [8:0] sd[$];
    logic [7:0] eb;
    logic [63:0] wd;
    wd = v.wd;
    @(negedge clk);
    check({tag, " ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_cmd = v.cmd; req_len = v.len; req_wdata = v.wd;
    lat = -1;
    for (int rel = 1; rel < 300 && lat < 0; rel++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (data_in_strobe) begin
        srel.push_back(rel);
        sd.push_back({data_in_start, data_in});
      end
      if (rsp_valid) lat = rel;
    end
    check({tag, " latency"}, 64'(lat), 64'(v.lat));
    check({tag, " rdata"}, rsp_rdata, v.rd);
    n_exp = ((v.len > 4'(MAX_LEN)) ? int'(MAX_LEN) : int'(v.len)) + 1;
    check({tag, " strobes"}, 64'(srel.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < srel.size(); i++) begin
      eb = (i == 0) ? v.cmd : wd[8*(i-1) +: 8];
      check($sformatf("%s strobe%0d", tag, i), {32'(srel[i]), 23'd0, sd[i]},
            {32'(1 + i*(GAP+1)), 23'd0, (i == 0), eb});
    end
    @(negedge clk);
    check({tag, " rsp pulse"}, {62'd0, rsp_valid, busy}, 64'd0);
  endtask

  vec_t vecs[4];
  int   cnt_a, cnt_b, t_rsp1, t_last1, t_start2, n_ready_hi;

  initial begin
    vecs[0] = '{cmd: CMD_STATUS,  len: 4'd3,  wd: 64'h0,
                lat: 21, rd: 64'h0000_0000_0002_425C};
    vecs[1] = '{cmd: CMD_CONFIG,  len: 4'd2,  wd: 64'h0341,
                lat: 16, rd: 64'h0000_0000_0002_FCBE};
    vecs[2] = '{cmd: CMD_INTSRC,  len: 4'd0,  wd: 64'hFFFF,
                lat: 6,  rd: 64'h0000_0000_0002_FCBE};
    vecs[3] = '{cmd: CMD_PORT_WR, len: 4'd12, wd: 64'h8877_6655_4433_2211,
                lat: 46, rd: 64'h7788_99AA_BBCC_DDEE};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", 64'(req_ready), 64'd0);
    check("reset busy", 64'(busy), 64'(BOOT_EN));
    check("reset outs", {46'd0, rsp_valid, data_in_strobe, data_in_start, data_in}, 64'd0);
    check("reset rdata", rsp_rdata, 64'd0);
    reset = 1'b0;

    // Boot table plays before the first req_ready.
    cnt_a = 0;
    for (int c = 0; c < 500 && !req_ready; c++) begin
      @(negedge clk);
      if (data_in_strobe && data_in_start) cnt_a++;
    end
    check("ready after reset", 64'(req_ready), 64'd1);
    check("boot frames", 64'(cnt_a), BOOT_EN ? 64'd3 : 64'd0);
    if (BOOT_EN) check("boot volume", 64'(m_vol), 64'd2);

    foreach (vecs[i]) run_frame($sformatf("vec%0d", i), vecs[i]);
    check("model volume", 64'(m_vol), 64'd3);

    // Held req_valid across two frames.
    @(negedge clk);
    req_valid = 1'b1; req_cmd = CMD_INTSRC; req_len = 4'd1; req_wdata = 64'h55;
    cnt_a = 0; t_rsp1 = -1; t_last1 = -1; t_start2 = -1; n_ready_hi = 0;
    for (int rel = 1; rel < 200 && cnt_a < 2; rel++) begin
      @(negedge clk);
      if (data_in_strobe && cnt_a == 0) t_last1 = rel;
      if (data_in_strobe && data_in_start && rel > 1) begin
        t_start2 = rel;
        req_valid = 1'b0;
      end
      if (req_ready) n_ready_hi++;
      if (rsp_valid) begin
        if (cnt_a == 0) t_rsp1 = rel;
        cnt_a++;
      end
    end
    check("b2b rsp count", 64'(cnt_a), 64'd2);
    check("b2b start2-rsp1", 64'(t_start2 - t_rsp1), 64'd2);
    check("b2b start2-last", 64'(t_start2 - t_last1), 64'(GAP + 3));
    check("b2b ready cycles", 64'(n_ready_hi), 64'd1);
    @(negedge clk);

    // Reset during the WAIT after payload 2 (strobe at cycle 11).
    req_valid = 1'b1; req_cmd = CMD_STATUS; req_len = 4'd3; req_wdata = '0;
    for (int rel = 1; rel <= 13; rel++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    check("pre-reset busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort strobe", 64'(data_in_strobe), 64'd0);
    check("abort busy", 64'(busy), 64'(BOOT_EN));
    check("abort rdata", rsp_rdata, 64'd0);
    check("abort ready", 64'(req_ready), 64'd0);
    reset = 1'b0;
    cnt_b = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid) cnt_b++;
    end
    check("abort no rsp", 64'(cnt_b), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
